// File: rtl/task_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : task_dispatch (with task_dispatch_pkg)
// Purpose  : Buffers ready tasks from the task queue and hands them to a core
//            on a type-matched dequeue. It also tracks busy threads, drops
//            aborted tasks and relays core start/finish notifications to the
//            commit queue.
// Revision : 1.0 - initial release
// ============================================================================

package task_dispatch_pkg;
  localparam int LOG_CQ_SLICE_SIZE = 4;

  typedef logic [3:0]                   task_type_t;
  typedef logic [LOG_CQ_SLICE_SIZE-1:0] cq_slice_slot_t;
  typedef logic [1:0]                   thread_id_t;
  typedef logic [2:0]                   child_id_t;

  typedef struct packed {
    task_type_t  ttype;
    logic [31:0] args;
  } task_t;
endpackage

module task_dispatch
  import task_dispatch_pkg::*;
#(
  parameter int TILE_ID   = 0,
  parameter int CORE_ID   = 0,
  parameter int DEPTH     = 4,
  parameter int N_THREADS = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  // upstream task queue
  input  logic                            tq_valid,
  output logic                            tq_ready,
  input  task_t                           tq_task,
  input  cq_slice_slot_t                  tq_slot,
  // core dequeue
  input  logic                            task_arvalid,
  input  task_type_t                      task_araddr,
  output logic                            task_rvalid,
  output task_t                           task_rdata,
  output cq_slice_slot_t                  task_rslot,
  output thread_id_t                      task_rthread,
  // core start notification
  input  logic                            start_task_valid,
  output logic                            start_task_ready,
  input  cq_slice_slot_t                  start_task_slot,
  // core finish notification
  input  logic                            finish_task_valid,
  output logic                            finish_task_ready,
  input  cq_slice_slot_t                  finish_task_slot,
  input  thread_id_t                      finish_task_thread,
  input  child_id_t                       finish_task_num_children,
  input  logic                            finish_task_undo_log_write,
  // commit queue side
  output logic                            cq_finish_valid,
  input  logic                            cq_finish_ready,
  output cq_slice_slot_t                  cq_finish_slot,
  output thread_id_t                      cq_finish_thread,
  output child_id_t                       cq_finish_num_children,
  output logic                            cq_finish_undo_log_write,
  output logic                            cq_start_valid,
  output cq_slice_slot_t                  cq_start_slot,
  // abort vector and statistics
  input  logic [2**LOG_CQ_SLICE_SIZE-1:0] task_aborted,
  output logic [31:0]                     stat_issued,
  output logic [31:0]                     stat_dropped
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  // Reject parameterisations the pointer/thread logic cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (N_THREADS < 1) || (N_THREADS > 2**$bits(thread_id_t)) ||
      (TILE_ID < 0) || (CORE_ID < 0)) begin : g_param_check
    $error("task_dispatch: illegal parameter set");
  end

  // Ready-task buffer storage and bookkeeping.
  task_t          fifo_task [DEPTH];
  cq_slice_slot_t fifo_slot [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             head_aborted;
  logic             push;
  logic             pop;
  logic             issue;
  logic             drop;

  // Thread tracking.
  logic [N_THREADS-1:0] busy;
  logic [N_THREADS-1:0] alloc_mask;
  logic [N_THREADS-1:0] free_mask;
  logic                 free_exists;
  thread_id_t           alloc_thread;
  logic                 finish_hs;

  // Start handshake FSM.
  logic [0:0]     state;
  logic [0:0]     state_next;
  cq_slice_slot_t start_slot_q;

  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign tq_ready     = !full;
  assign task_rdata   = fifo_task[rd_ptr];
  assign task_rslot   = fifo_slot[rd_ptr];
  assign head_aborted = task_aborted[task_rslot];

  assign task_rvalid  = task_arvalid && !empty && (task_rdata.ttype == task_araddr) &&
                        !head_aborted && free_exists;
  assign task_rthread = alloc_thread;
  assign issue        = task_arvalid && task_rvalid;
  assign drop         = !empty && head_aborted;
  assign pop          = issue || drop;
  // A full buffer still takes the incoming entry when the head leaves this cycle.
  assign push         = tq_valid && (!full || pop);

  // Pick the lowest-index free thread from the current (pre-update) bitmap.
  always_comb begin
    free_exists  = 1'b0;
    alloc_thread = '0;
    for (int i = N_THREADS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_exists  = 1'b1;
        alloc_thread = thread_id_t'(i);
      end
    end
  end

  // Per-thread set/clear masks; a finish only clears a thread that is really busy.
  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      alloc_mask[i] = issue && (alloc_thread == thread_id_t'(i));
      free_mask[i]  = finish_hs && (finish_task_thread == thread_id_t'(i)) && busy[i];
    end
  end

  // Buffer payload storage; needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_task[wr_ptr] <= tq_task;
      fifo_slot[wr_ptr] <= tq_slot;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Busy-thread bitmap: frees from a finish take effect the cycle after it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~free_mask) | alloc_mask;
    end
  end

  // Issue and drop counters, wrapping naturally at 2**32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_issued  <= '0;
      stat_dropped <= '0;
    end else begin
      if (issue) stat_issued  <= stat_issued + 32'd1;
      if (drop)  stat_dropped <= stat_dropped + 32'd1;
    end
  end

  assign finish_task_ready = !cq_finish_valid || cq_finish_ready;
  assign finish_hs         = finish_task_valid && finish_task_ready;

  // One-entry finish register toward the commit queue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cq_finish_valid          <= 1'b0;
      cq_finish_slot           <= '0;
      cq_finish_thread         <= '0;
      cq_finish_num_children   <= '0;
      cq_finish_undo_log_write <= 1'b0;
    end else if (finish_hs) begin
      cq_finish_valid          <= 1'b1;
      cq_finish_slot           <= finish_task_slot;
      cq_finish_thread         <= finish_task_thread;
      cq_finish_num_children   <= finish_task_num_children;
      cq_finish_undo_log_write <= finish_task_undo_log_write;
    end else if (cq_finish_ready) begin
      cq_finish_valid          <= 1'b0;
    end
  end

`ifdef DEBUG
  // Flag finishes that name a thread that was never issued.
  always_ff @(posedge clk) begin
    if (finish_hs && (free_mask == '0)) begin
      $display("task_dispatch[tile %0d core %0d]: finish for idle thread %0d",
               TILE_ID, CORE_ID, finish_task_thread);
    end
  end
`endif

  // Start FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start FSM next state: acknowledge lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_task_valid) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the start slot while idle so it is stable during the ack cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_slot_q <= '0;
    end else if ((state == S_IDLE) && start_task_valid) begin
      start_slot_q <= start_task_slot;
    end
  end

  // Start FSM outputs.
  always_comb begin
    start_task_ready = (state == S_ACK);
    cq_start_valid   = (state == S_ACK);
    cq_start_slot    = start_slot_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_task_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_task_dispatch
// Purpose  : Directed self-checking bench for task_dispatch (DEPTH=4, 2 threads).
// Revision : 1.0 - initial release
// ============================================================================
module tb_task_dispatch;
  import task_dispatch_pkg::*;

  logic           clk = 1'b0;
  logic           rstn;
  logic           tq_valid;
  logic           tq_ready;
  task_t          tq_task;
  cq_slice_slot_t tq_slot;
  logic           task_arvalid;
  task_type_t     task_araddr;
  logic           task_rvalid;
  task_t          task_rdata;
  cq_slice_slot_t task_rslot;
  thread_id_t     task_rthread;
  logic           start_task_valid;
  logic           start_task_ready;
  cq_slice_slot_t start_task_slot;
  logic           finish_task_valid;
  logic           finish_task_ready;
  cq_slice_slot_t finish_task_slot;
  thread_id_t     finish_task_thread;
  child_id_t      finish_task_num_children;
  logic           finish_task_undo_log_write;
  logic           cq_finish_valid;
  logic           cq_finish_ready;
  cq_slice_slot_t cq_finish_slot;
  thread_id_t     cq_finish_thread;
  child_id_t      cq_finish_num_children;
  logic           cq_finish_undo_log_write;
  logic           cq_start_valid;
  cq_slice_slot_t cq_start_slot;
  logic [15:0]    task_aborted;
  logic [31:0]    stat_issued;
  logic [31:0]    stat_dropped;

  int n_checks = 0;
  int n_errors = 0;

  task_dispatch #(.TILE_ID(0), .CORE_ID(0), .DEPTH(4), .N_THREADS(2)) dut (
    .clk(clk), .rstn(rstn),
    .tq_valid(tq_valid), .tq_ready(tq_ready), .tq_task(tq_task), .tq_slot(tq_slot),
    .task_arvalid(task_arvalid), .task_araddr(task_araddr), .task_rvalid(task_rvalid),
    .task_rdata(task_rdata), .task_rslot(task_rslot), .task_rthread(task_rthread),
    .start_task_valid(start_task_valid), .start_task_ready(start_task_ready),
    .start_task_slot(start_task_slot),
    .finish_task_valid(finish_task_valid), .finish_task_ready(finish_task_ready),
    .finish_task_slot(finish_task_slot), .finish_task_thread(finish_task_thread),
    .finish_task_num_children(finish_task_num_children),
    .finish_task_undo_log_write(finish_task_undo_log_write),
    .cq_finish_valid(cq_finish_valid), .cq_finish_ready(cq_finish_ready),
    .cq_finish_slot(cq_finish_slot), .cq_finish_thread(cq_finish_thread),
    .cq_finish_num_children(cq_finish_num_children),
    .cq_finish_undo_log_write(cq_finish_undo_log_write),
    .cq_start_valid(cq_start_valid), .cq_start_slot(cq_start_slot),
    .task_aborted(task_aborted), .stat_issued(stat_issued), .stat_dropped(stat_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic task_t mk(input task_type_t t, input logic [31:0] a);
    task_t r;
    r.ttype = t;
    r.args  = a;
    return r;
  endfunction

  task automatic finish_req(input cq_slice_slot_t s, input thread_id_t th,
                            input child_id_t ch, input logic u);
    finish_task_valid          = 1'b1;
    finish_task_slot           = s;
    finish_task_thread         = th;
    finish_task_num_children   = ch;
    finish_task_undo_log_write = u;
  endtask

  initial begin
    rstn = 1'b0;
    tq_valid = 1'b0; tq_task = '0; tq_slot = '0;
    task_arvalid = 1'b0; task_araddr = '0;
    start_task_valid = 1'b0; start_task_slot = '0;
    finish_task_valid = 1'b0; finish_task_slot = '0; finish_task_thread = '0;
    finish_task_num_children = '0; finish_task_undo_log_write = 1'b0;
    cq_finish_ready = 1'b1; task_aborted = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    task_arvalid = 1'b1;
    #1;
    chk("rst_tq_ready", tq_ready, 1);
    chk("rst_rvalid", task_rvalid, 0);
    chk("rst_start_ready", start_task_ready, 0);
    chk("rst_cq_start_valid", cq_start_valid, 0);
    chk("rst_cq_finish_valid", cq_finish_valid, 0);
    chk("rst_finish_ready", finish_task_ready, 1);
    chk("rst_stat_issued", stat_issued, 0);
    chk("rst_stat_dropped", stat_dropped, 0);
    task_arvalid = 1'b0;
    rstn = 1'b1;
    tick();

    // ---------------- in-order issue, thread exhaustion ----------------
    task_arvalid = 1'b1; task_araddr = 4'd0;
    tq_valid = 1'b1; tq_task = mk(4'd0, 32'h105); tq_slot = 4'd5;
    #1 chk("t1_empty_rvalid", task_rvalid, 0);
    tick();
    tq_task = mk(4'd0, 32'h106); tq_slot = 4'd6;
    #1;
    chk("t1_rvalid5", task_rvalid, 1);
    chk("t1_rslot5", task_rslot, 5);
    chk("t1_rthread5", task_rthread, 0);
    chk("t1_rdata5", task_rdata, mk(4'd0, 32'h105));
    tick();
    tq_task = mk(4'd0, 32'h107); tq_slot = 4'd7;
    #1;
    chk("t1_rvalid6", task_rvalid, 1);
    chk("t1_rslot6", task_rslot, 6);
    chk("t1_rthread6", task_rthread, 1);
    tick();
    tq_valid = 1'b0;
    #1 chk("t1_no_thread_a", task_rvalid, 0);
    tick();
    #1;
    chk("t1_no_thread_b", task_rvalid, 0);
    chk("t1_stat_issued2", stat_issued, 2);
    finish_req(4'd5, 2'd0, 3'd2, 1'b0);
    #1;
    chk("t1_finish_ready", finish_task_ready, 1);
    chk("t1_pre_update_bitmap", task_rvalid, 0);
    tick();
    finish_task_valid = 1'b0;
    #1;
    chk("t1_cq_finish_valid", cq_finish_valid, 1);
    chk("t1_cq_finish_slot", cq_finish_slot, 5);
    chk("t1_cq_finish_thread", cq_finish_thread, 0);
    chk("t1_rvalid7", task_rvalid, 1);
    chk("t1_rslot7", task_rslot, 7);
    chk("t1_rthread7", task_rthread, 0);
    tick();
    task_arvalid = 1'b0;
    #1;
    chk("t1_stat_issued3", stat_issued, 3);
    chk("t1_cq_finish_clear", cq_finish_valid, 0);

    // ---------------- finish back-pressure ----------------
    cq_finish_ready = 1'b0;
    finish_req(4'd3, 2'd1, 3'd4, 1'b1);
    #1 chk("t2_finish_ready_first", finish_task_ready, 1);
    tick();
    finish_req(4'd2, 2'd0, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_finish_ready_blocked", finish_task_ready, 0);
      chk("t2_hold_valid", cq_finish_valid, 1);
      chk("t2_hold_slot", cq_finish_slot, 3);
      chk("t2_hold_thread", cq_finish_thread, 1);
      chk("t2_hold_children", cq_finish_num_children, 4);
      chk("t2_hold_undo", cq_finish_undo_log_write, 1);
      tick();
    end
    cq_finish_ready = 1'b1;
    #1 chk("t2_finish_ready_drain", finish_task_ready, 1);
    tick();
    finish_task_valid = 1'b0;
    #1;
    chk("t2_second_valid", cq_finish_valid, 1);
    chk("t2_second_slot", cq_finish_slot, 2);
    chk("t2_second_thread", cq_finish_thread, 0);
    tick();
    #1 chk("t2_drained", cq_finish_valid, 0);

    // ---------------- head type mismatch blocks ----------------
    task_arvalid = 1'b1; task_araddr = 4'd0;
    tq_valid = 1'b1; tq_task = mk(4'd2, 32'h2a2); tq_slot = 4'd1;
    tick();
    tq_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t3_blocked_rvalid", task_rvalid, 0);
      chk("t3_blocked_tq_ready", tq_ready, 1);
      tick();
    end
    task_araddr = 4'd2;
    #1;
    chk("t3_rvalid", task_rvalid, 1);
    chk("t3_rslot", task_rslot, 1);
    chk("t3_rthread", task_rthread, 0);
    chk("t3_rdata", task_rdata, mk(4'd2, 32'h2a2));
    tick();
    task_arvalid = 1'b0;
    #1 chk("t3_stat_issued4", stat_issued, 4);
    finish_req(4'd1, 2'd0, 3'd0, 1'b0);
    tick();
    finish_task_valid = 1'b0;
    tick();

    // ---------------- aborted head is dropped ----------------
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    #1 chk("t4_stats_cleared", {stat_issued, stat_dropped}, 64'd0);
    tq_valid = 1'b1; tq_task = mk(4'd0, 32'h909); tq_slot = 4'd9;
    tick();
    tq_task = mk(4'd0, 32'h910); tq_slot = 4'd10;
    tick();
    tq_valid = 1'b0;
    task_aborted = 16'h0200;
    task_arvalid = 1'b1; task_araddr = 4'd0;
    #1 chk("t4_head_aborted_rvalid", task_rvalid, 0);
    tick();
    #1;
    chk("t4_stat_dropped1", stat_dropped, 1);
    chk("t4_rvalid10", task_rvalid, 1);
    chk("t4_rslot10", task_rslot, 10);
    chk("t4_rthread10", task_rthread, 0);
    tick();
    #1;
    chk("t4_stat_issued1", stat_issued, 1);
    chk("t4_stat_dropped_same", stat_dropped, 1);
    chk("t4_empty_rvalid", task_rvalid, 0);
    task_aborted = '0; task_arvalid = 1'b0;
    finish_req(4'd10, 2'd0, 3'd0, 1'b0);
    tick();
    finish_task_valid = 1'b0;
    tick();

    // ---------------- full buffer, push with pop ----------------
    tq_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tq_task = mk(4'd3, 32'h300 + k); tq_slot = cq_slice_slot_t'(11 + k);
      tick();
    end
    tq_task = mk(4'd3, 32'h30f); tq_slot = 4'd15;
    #1 chk("t5_full_tq_ready", tq_ready, 0);
    task_arvalid = 1'b1; task_araddr = 4'd3;
    #1;
    chk("t5_pop_tq_ready", tq_ready, 0);
    chk("t5_rvalid11", task_rvalid, 1);
    chk("t5_rslot11", task_rslot, 11);
    chk("t5_rthread11", task_rthread, 0);
    tick();
    tq_valid = 1'b0; task_arvalid = 1'b0;
    #1 chk("t5_still_full", tq_ready, 0);
    task_aborted = 16'h7000;
    tick();
    #1;
    chk("t5_drop12", stat_dropped, 2);
    chk("t5_not_full", tq_ready, 1);
    tick();
    #1 chk("t5_drop13", stat_dropped, 3);
    tick();
    #1 chk("t5_drop14", stat_dropped, 4);
    task_arvalid = 1'b1;
    #1;
    chk("t5_rvalid15", task_rvalid, 1);
    chk("t5_rslot15", task_rslot, 15);
    chk("t5_rthread15", task_rthread, 1);
    tick();
    #1;
    chk("t5_stat_issued3", stat_issued, 3);
    chk("t5_empty", task_rvalid, 0);
    task_arvalid = 1'b0; task_aborted = '0;

    // ---------------- start path and reset during ack ----------------
    tq_valid = 1'b1; tq_task = mk(4'd0, 32'h501); tq_slot = 4'd1;
    tick();
    tq_task = mk(4'd0, 32'h502); tq_slot = 4'd2;
    tick();
    tq_valid = 1'b0;
    start_task_valid = 1'b1; start_task_slot = 4'd4;
    #1 chk("t6_idle_ready", start_task_ready, 0);
    tick();
    start_task_valid = 1'b0;
    #1;
    chk("t6_ack_ready", start_task_ready, 1);
    chk("t6_ack_cq_valid", cq_start_valid, 1);
    chk("t6_ack_cq_slot", cq_start_slot, 4);
    tick();
    #1;
    chk("t6_one_cycle_ready", start_task_ready, 0);
    chk("t6_one_cycle_cq", cq_start_valid, 0);
    cq_finish_ready = 1'b0;
    finish_req(4'd7, 2'd1, 3'd3, 1'b1);
    start_task_valid = 1'b1; start_task_slot = 4'd6;
    tick();
    finish_task_valid = 1'b0; start_task_valid = 1'b0;
    #1;
    chk("t6_ack2_ready", start_task_ready, 1);
    chk("t6_pending_finish", cq_finish_valid, 1);
    rstn = 1'b0;
    task_arvalid = 1'b1; task_araddr = 4'd0;
    #1;
    chk("t6_rst_start_ready", start_task_ready, 0);
    chk("t6_rst_cq_start", cq_start_valid, 0);
    chk("t6_rst_cq_finish", cq_finish_valid, 0);
    chk("t6_rst_tq_ready", tq_ready, 1);
    chk("t6_rst_rvalid", task_rvalid, 0);
    chk("t6_rst_stats", {stat_issued, stat_dropped}, 64'd0);
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_post_start_ready", start_task_ready, 0);
      chk("t6_post_cq_start", cq_start_valid, 0);
      chk("t6_post_cq_finish", cq_finish_valid, 0);
      chk("t6_post_rvalid", task_rvalid, 0);
      chk("t6_post_stat_issued", stat_issued, 0);
      tick();
    end
    tq_valid = 1'b1; tq_task = mk(4'd0, 32'h808); tq_slot = 4'd8;
    tick();
    tq_valid = 1'b0;
    #1;
    chk("t6_fresh_rvalid", task_rvalid, 1);
    chk("t6_fresh_rslot", task_rslot, 8);
    chk("t6_fresh_rthread", task_rthread, 0);
    tick();
    task_arvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/task_dispatch.md
TASK_DISPATCH -- requirements
Module: task_dispatch

Interface
REQ-001 SHALL have parameter TILE_ID, default 0, meaning tile index used in debug output only.
REQ-002 SHALL have parameter CORE_ID, default 0, meaning served-core index used in debug output only.
REQ-003 SHALL have parameter DEPTH, default 4, meaning ready-task buffer entries; power of 2, >=2.
REQ-004 SHALL have parameter N_THREADS, default 2, meaning thread ids issuable concurrently, <= 2**$bits(thread_id_t).
REQ-005 SHALL have ports: clk input 1 clock; rstn input 1 reset, asynchronous, active-low.
REQ-006 SHALL have upstream ports: tq_valid in 1; tq_ready out 1; tq_task in task_t; tq_slot in cq_slice_slot_t.
REQ-007 SHALL have core dequeue ports: task_arvalid in 1; task_araddr in task_type_t; task_rvalid out 1; task_rdata out task_t; task_rslot out cq_slice_slot_t; task_rthread out thread_id_t.
REQ-008 SHALL have core start ports: start_task_valid in 1; start_task_ready out 1; start_task_slot in cq_slice_slot_t.
REQ-009 SHALL have core finish ports: finish_task_valid in 1; finish_task_ready out 1; finish_task_slot in cq_slice_slot_t; finish_task_thread in thread_id_t; finish_task_num_children in child_id_t; finish_task_undo_log_write in 1.
REQ-010 SHALL have CQ ports: cq_finish_valid out 1; cq_finish_ready in 1; cq_finish_slot/thread/num_children/undo_log_write out (types as REQ-009); cq_start_valid out 1; cq_start_slot out cq_slice_slot_t.
REQ-011 SHALL have task_aborted in 2**LOG_CQ_SLICE_SIZE, one bit per CQ slot; stat_issued out 32; stat_dropped out 32.

Function
REQ-012 SHALL hold up to DEPTH {task, slot} entries in FIFO order; tq_ready = !full; push on tq_valid & tq_ready.
REQ-013 SHALL compute task_rvalid combinationally, same cycle: task_arvalid & !empty & head.ttype == task_araddr & !task_aborted[head.slot] & free thread exists.
REQ-014 task_rdata/task_rslot SHALL be head entry; task_rthread SHALL be lowest-index free thread; handshake = task_arvalid & task_rvalid.
REQ-015 On handshake SHALL pop head, mark thread busy, increment stat_issued (wraps at 2**32).
REQ-016 Head ttype mismatch SHALL block (no bypass of younger entries); no pop.
REQ-017 Head with task_aborted[head.slot]=1 SHALL be popped without issue in that cycle regardless of task_arvalid, stat_dropped +1; one drop per cycle max.
REQ-018 Push and pop/drop in same cycle SHALL both occur when full (count unchanged); empty push SHALL not be served before the next cycle.
REQ-019 Start path: 2-state FSM S_IDLE/S_ACK; S_IDLE & start_task_valid -> S_ACK; S_ACK drives start_task_ready=1, cq_start_valid=1, cq_start_slot=registered start_task_slot for exactly one cycle, then -> S_IDLE.
REQ-020 Finish path: one-entry output register; finish_task_ready = !cq_finish_valid | cq_finish_ready.
REQ-021 On finish handshake SHALL load cq_finish_* from finish_task_* (cq_finish_valid=1 next cycle) and free finish_task_thread the next cycle.
REQ-022 cq_finish_valid SHALL hold with stable payload until cq_finish_ready; clear when ready and no new load.
REQ-023 Thread freed and thread allocated in same cycle SHALL use pre-update bitmap for allocation; freed thread reusable next cycle.
REQ-024 Finish for a thread not busy SHALL be accepted and forwarded; bitmap unchanged (DEBUG build SHALL $display error with TILE_ID/CORE_ID).

Reset
REQ-025 rstn low SHALL asynchronously: empty FIFO, all threads free, FSM S_IDLE, cq_finish_valid=0, cq_start_valid=0, start_task_ready=0, stats=0; tq_ready=1 and task_rvalid=0 while in reset.
REQ-026 Reset mid-handshake SHALL discard buffered tasks and pending finish; no output pulse on release.

Verification
REQ-027 Push 3 tasks ttype 0 slots 5,6,7; task_arvalid=1 araddr=0 -> issued slots 5,6 threads 0,1 on consecutive cycles; slot 7 waits until a finish frees thread 0.
REQ-028 Fill DEPTH=4; assert tq_valid with pop same cycle -> tq_ready=0, push and pop both occur, count stays 4.
REQ-029 Head slot 9 with task_aborted[9]=1, next entry slot 10 -> slot 9 dropped, stat_dropped=1, slot 10 issued next cycle, stat_issued=1.
REQ-030 Head ttype 2, task_araddr=0 -> task_rvalid=0 for 10 cycles, FIFO unchanged; araddr=2 -> issued.
REQ-031 Finish slot 3 thread 1 children 4 undo 1 with cq_finish_ready=0 for 3 cycles -> cq_finish_valid held, payload stable, finish_task_ready=0 until drained.
REQ-032 rstn low during S_ACK with 2 buffered tasks -> start_task_ready=0 immediately, FIFO empty, stats 0 after release.
